// File: rtl/inv_sbyteswrap.sv
// AES InvSubBytes wrapper: reads one 128-bit state from SRAM, substitutes 4 bytes per cycle, writes it back.
// Optional build macro INV_SBYTES_DUMP_EN adds a one-cycle SRAM dump after the write.
module inv_sbyteswrap #(
   parameter logic [15:0] SRC_ADDR = 16'h0000,
   parameter logic [15:0] DST_ADDR = 16'h0000,
   parameter logic [2:0]  DUMP_NUM = 3'd0
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         inv_sbytes_enable,
   output logic         inv_sbytes_finished,
   input  logic [127:0] sramread_data,
   output logic [127:0] sramwrite_data,
   output logic         sramread,
   output logic         sramwrite,
   output logic         sramdump,
   output logic         sraminit,
   output logic [15:0]  sramaddr,
   output logic [2:0]   sramdumpnum,
   output logic [2:0]   sraminitnum
);

   typedef enum logic [3:0] {
      IDLE, READ, SUB0, SUB1, SUB2, SUB3, WRITE,
`ifdef INV_SBYTES_DUMP_EN
      DUMP,
`endif
      DONE
   } stateT;

   stateT state, nextState;
   logic [127:0] stateReg;
   logic [1:0]   laneSel;
   logic [31:0]  laneIn, subWord;

   function automatic logic [7:0] invSbox(input logic [7:0] b);
      logic [7:0] r;
      r = 8'h00;
      case (b)
         8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
         8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
         8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
         8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
         8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
         8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
         8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
         8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
         8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
         8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
         8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
         8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
         8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
         8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
         8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
         8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
         8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
         8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
         8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
         8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
         8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
         8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
         8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
         8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
         8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
         8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
         8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
         8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
         8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
         8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
         8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
         8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   // State register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= nextState;
   end

   // Next-state logic; DONE waits for enable to drop so a held request never retriggers
   always_comb begin
      nextState = state;
      case (state)
         IDLE:  if (inv_sbytes_enable) nextState = READ;
         READ:  nextState = SUB0;
         SUB0:  nextState = SUB1;
         SUB1:  nextState = SUB2;
         SUB2:  nextState = SUB3;
         SUB3:  nextState = WRITE;
`ifdef INV_SBYTES_DUMP_EN
         WRITE: nextState = DUMP;
         DUMP:  nextState = DONE;
`else
         WRITE: nextState = DONE;
`endif
         DONE:  if (!inv_sbytes_enable) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Output decode, purely from registered state
   always_comb begin
      sramread            = 1'b0;
      sramwrite           = 1'b0;
      sramdump            = 1'b0;
      sramaddr            = 16'h0000;
      inv_sbytes_finished = 1'b0;
      case (state)
         READ:  begin sramread  = 1'b1; sramaddr = SRC_ADDR; end
         WRITE: begin sramwrite = 1'b1; sramaddr = DST_ADDR; end
`ifdef INV_SBYTES_DUMP_EN
         DUMP:  sramdump = 1'b1;
`endif
         DONE:  inv_sbytes_finished = 1'b1;
         default: ;
      endcase
   end

   assign sramdumpnum    = DUMP_NUM & {3{sramdump}};
   assign sraminit       = 1'b0;
   assign sraminitnum    = 3'd0;
   assign sramwrite_data = stateReg;

   always_comb begin
      laneSel = 2'd0;
      case (state)
         SUB1:    laneSel = 2'd1;
         SUB2:    laneSel = 2'd2;
         SUB3:    laneSel = 2'd3;
         default: laneSel = 2'd0;
      endcase
   end

   assign laneIn = stateReg[{laneSel, 5'd0} +: 32];

   for (genvar j = 0; j < 4; j++) begin : gLane
      assign subWord[8*j +: 8] = invSbox(laneIn[8*j +: 8]);
   end

   // Data register: load on READ, then overwrite one 32-bit lane per SUB state
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         stateReg <= '0;
      end else begin
         case (state)
            READ:                   stateReg <= sramread_data;
            SUB0, SUB1, SUB2, SUB3: stateReg[{laneSel, 5'd0} +: 32] <= subWord;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_sbyteswrap.sv
// Scoreboard bench for inv_sbyteswrap: GF(2^8) reference model, random states, timing and reset checks.
// Honours INV_SBYTES_DUMP_EN when the design is built with it.
module tb_inv_sbyteswrap;

   localparam logic [15:0] SRC = 16'h0000;
   localparam logic [15:0] DST = 16'h0000;
`ifdef INV_SBYTES_DUMP_EN
   localparam int FIN_LAT = 8;
`else
   localparam int FIN_LAT = 7;
`endif

   logic         clk, n_rst, inv_sbytes_enable, inv_sbytes_finished;
   logic [127:0] sramread_data, sramwrite_data;
   logic         sramread, sramwrite, sramdump, sraminit;
   logic [15:0]  sramaddr;
   logic [2:0]   sramdumpnum, sraminitnum;

   logic [127:0] mem [0:3];
   logic [127:0] expQ [$];
   logic [127:0] expData;
   logic [7:0]   fwdTable [0:255];
   logic [7:0]   invTable [0:255];
   int checks = 0;
   int errors = 0;

   inv_sbyteswrap #(.SRC_ADDR(SRC), .DST_ADDR(DST), .DUMP_NUM(3'd2)) dut (
      .clk(clk), .n_rst(n_rst), .inv_sbytes_enable(inv_sbytes_enable),
      .inv_sbytes_finished(inv_sbytes_finished), .sramread_data(sramread_data),
      .sramwrite_data(sramwrite_data), .sramread(sramread), .sramwrite(sramwrite),
      .sramdump(sramdump), .sraminit(sraminit), .sramaddr(sramaddr),
      .sramdumpnum(sramdumpnum), .sraminitnum(sraminitnum)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Combinational SRAM model
   assign sramread_data = sramread ? mem[sramaddr[1:0]] : 128'h0;
   always @(posedge clk) if (sramwrite) mem[sramaddr[1:0]] = sramwrite_data;

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic hi;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r = 8'h00;
      for (int x = 1; x < 256; x++)
         if (gmul(a, 8'(x)) == 8'h01) r = 8'(x);
      return r;
   endfunction

   // Forward S-box: multiplicative inverse followed by the AES affine map
   function automatic logic [7:0] sboxFn(input logic [7:0] x);
      logic [7:0] v;
      v = ginv(x);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] subBytes(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = fwdTable[s[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] invSubBytes(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = invTable[s[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Monitor: pops the scoreboard whenever the DUT writes
   always @(negedge clk) begin
      if (n_rst && sramwrite) begin
         checkOutput("writeExpected", 128'(expQ.size() != 0), 128'(1));
         if (expQ.size() != 0) begin
            expData = expQ.pop_front();
            checkOutput("writeData", sramwrite_data, expData);
         end
      end
      if (n_rst && (sramread || sramwrite))
         checkOutput("readWriteExclusive", 128'(sramread && sramwrite), 128'(0));
   end

   task automatic applyStimulus(input logic [127:0] src, input logic [127:0] expWrite, input int holdCycles, input bit pulse);
      int firstRead = -1, firstWrite = -1, firstFin = -1, lastFin = -1, firstDump = -1;
      int nRead = 0, nWrite = 0, nDump = 0, finCount = 0;
      bit addrBad = 0, tieBad = 0;
      logic [2:0] dumpNum = 3'd0;
      mem[SRC[1:0]] = src;
      expQ.push_back(expWrite);
      @(negedge clk);
      inv_sbytes_enable = 1'b1;
      for (int k = 1; k <= 20 + holdCycles; k++) begin
         @(negedge clk);
         if (sramread) begin
            nRead++;
            if (firstRead < 0) firstRead = k;
            if (sramaddr != SRC) addrBad = 1;
         end
         if (sramwrite) begin
            nWrite++;
            if (firstWrite < 0) firstWrite = k;
            if (sramaddr != DST) addrBad = 1;
         end
         if (!sramread && !sramwrite && sramaddr != 16'h0) addrBad = 1;
         if (sraminit || sraminitnum != 3'd0) tieBad = 1;
         if (sramdump) begin
            nDump++;
            if (firstDump < 0) firstDump = k;
            dumpNum = sramdumpnum;
         end else if (sramdumpnum != 3'd0) tieBad = 1;
         if (inv_sbytes_finished) begin
            if (firstFin < 0) firstFin = k;
            lastFin = k;
            finCount++;
         end
         if (inv_sbytes_enable) begin
            if (pulse && k == 1) inv_sbytes_enable = 1'b0;
            else if (!pulse && inv_sbytes_finished && finCount > holdCycles) inv_sbytes_enable = 1'b0;
         end
      end
      inv_sbytes_enable = 1'b0;
      checkOutput("readCycle", 128'(firstRead), 128'(1));
      checkOutput("readCount", 128'(nRead), 128'(1));
      checkOutput("writeCycle", 128'(firstWrite), 128'(6));
      checkOutput("writeCount", 128'(nWrite), 128'(1));
      checkOutput("finishedRise", 128'(firstFin), 128'(FIN_LAT));
      checkOutput("finishedFall", 128'(lastFin), 128'(pulse ? FIN_LAT : FIN_LAT + holdCycles));
      checkOutput("addressDecode", 128'(addrBad), 128'(0));
      checkOutput("tiedOutputs", 128'(tieBad), 128'(0));
`ifdef INV_SBYTES_DUMP_EN
      checkOutput("dumpCount", 128'(nDump), 128'(1));
      checkOutput("dumpCycle", 128'(firstDump), 128'(7));
      checkOutput("dumpNum", 128'(dumpNum), 128'(2));
`else
      checkOutput("dumpCount", 128'(nDump), 128'(0));
`endif
   endtask

   task automatic checkResetOutputs(input string name);
      checkOutput({name, "Strobes"},
                  128'({sramread, sramwrite, sramdump, sraminit, inv_sbytes_finished, sramaddr, sramdumpnum, sraminitnum}),
                  128'(0));
      checkOutput({name, "WriteData"}, sramwrite_data, 128'(0));
   endtask

   // Reset asserted while the DUT sits in SUB2; the SRAM must not see any write
   task automatic resetMidOp(input logic [127:0] pattern);
      mem[SRC[1:0]] = pattern;
      @(negedge clk);
      inv_sbytes_enable = 1'b1;
      for (int k = 1; k <= 4; k++) @(negedge clk);
      n_rst = 1'b0;
      inv_sbytes_enable = 1'b0;
      #1;
      checkResetOutputs("midReset");
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      repeat (8) @(negedge clk);
      checkOutput("dstUnchanged", mem[DST[1:0]], pattern);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [127:0] r;
      for (int x = 0; x < 256; x++) begin
         fwdTable[x] = sboxFn(8'(x));
         invTable[fwdTable[x]] = 8'(x);
      end
      for (int i = 0; i < 4; i++) mem[i] = 128'h0;
      n_rst = 1'b0;
      inv_sbytes_enable = 1'b0;
      repeat (2) @(negedge clk);
      checkResetOutputs("initReset");
      n_rst = 1'b1;
      @(negedge clk);

      applyStimulus(128'h30_52_41_1E_E5_5D_B4_B8_F1_98_BF_E0_AE_11_27_D4,
                    128'h08_48_F8_E9_2A_8D_C6_9A_2B_E2_F4_A0_BE_E3_3D_19, 0, 1'b1);
      applyStimulus({16{8'h63}}, {16{8'h00}}, 0, 1'b1);
      applyStimulus({16{8'h7C}}, {16{8'h01}}, 0, 1'b1);
      for (int t = 0; t < 3; t++) begin
         r = rand128();
         applyStimulus(subBytes(r), r, 0, 1'b1);
      end
      for (int t = 0; t < 3; t++) begin
         r = rand128();
         applyStimulus(r, invSubBytes(r), 2, 1'b0);
      end
      r = rand128();
      applyStimulus(r, invSubBytes(r), 10, 1'b0);

      resetMidOp(128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
      r = rand128();
      applyStimulus(subBytes(r), r, 0, 1'b1);

      repeat (3) @(negedge clk);
      checkOutput("scoreboardEmpty", 128'(expQ.size()), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
